// File: rtl/alu_seq_ctrl_pkg.sv
// Shared control-signal header for the serial add/subtract ALU and its sequencer:
// ALU opcodes and sequencer state encodings.
package alu_seq_ctrl_pkg;

  localparam int ACC_W = 12;

  typedef enum logic {
    ALU_OP_ADD1 = 1'b0,
    ALU_OP_SUB1 = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer stepping the serial ALU once per activation/weight bit pair and owning the accumulator.
// Optional feature macro: SEQ_CTRL_THRESH_EN (adds thresh_in / act_out threshold compare).
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int N_IN  = 64,
  parameter int CNT_W = $clog2(N_IN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_IN-1:0]         a_vec,
  input  logic [N_IN-1:0]         w_vec,
  input  logic signed [ACC_W-1:0] bias_in,
`ifdef SEQ_CTRL_THRESH_EN
  input  logic signed [ACC_W-1:0] thresh_in,
  output logic                    act_out,
`endif
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    alu_in_a_lsb,
  output logic signed [ACC_W-1:0] alu_in_b,
  output logic                    alu_op,
  input  logic signed [ACC_W-1:0] alu_out
);

  seq_state_e              state_q;
  logic [N_IN-1:0]         a_sh_q, a_sh_d;
  logic [N_IN-1:0]         w_sh_q, w_sh_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] result_q;
  logic                    busy_q;
  logic                    out_valid_q;
  logic                    lsb_q;
  alu_op_e                 op_q;
  logic                    last_step_s;
`ifdef SEQ_CTRL_THRESH_EN
  logic signed [ACC_W-1:0] thresh_q;
  logic                    act_q;
`endif

  always_comb begin
    a_sh_d      = a_sh_q >> 1;
    w_sh_d      = w_sh_q >> 1;
    last_step_s = (cnt_q == CNT_W'(N_IN - 1));
  end

  // Operand bit and opcode are registered one step ahead so the ALU sees a_sh[0]/w_sh[0] during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      w_sh_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      lsb_q       <= 1'b0;
      op_q        <= ALU_OP_ADD1;
`ifdef SEQ_CTRL_THRESH_EN
      thresh_q    <= '0;
      act_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            a_sh_q  <= a_vec;
            w_sh_q  <= w_vec;
            acc_q   <= bias_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            lsb_q   <= a_vec[0];
            op_q    <= w_vec[0] ? ALU_OP_ADD1 : ALU_OP_SUB1;
`ifdef SEQ_CTRL_THRESH_EN
            thresh_q <= thresh_in;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q  <= alu_out;
          a_sh_q <= a_sh_d;
          w_sh_q <= w_sh_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step_s) begin
            // The final sum is alu_out this cycle; publish it together with the valid pulse.
            state_q     <= DONE;
            result_q    <= alu_out;
            out_valid_q <= 1'b1;
            lsb_q       <= 1'b0;
            op_q        <= ALU_OP_ADD1;
`ifdef SEQ_CTRL_THRESH_EN
            act_q       <= (alu_out >= thresh_q);
`endif
          end else begin
            state_q <= RUN;
            lsb_q   <= a_sh_d[0];
            op_q    <= w_sh_d[0] ? ALU_OP_ADD1 : ALU_OP_SUB1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          lsb_q       <= 1'b0;
          op_q        <= ALU_OP_ADD1;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign alu_in_a_lsb = lsb_q;
  assign alu_in_b     = acc_q;
  assign alu_op       = op_q;
`ifdef SEQ_CTRL_THRESH_EN
  assign act_out      = act_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with N_IN=8 and a behavioural serial ALU beside it.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N-1:0]      a_vec;
  logic [N-1:0]      w_vec;
  logic signed [11:0] bias_in;
  logic              busy;
  logic              out_valid;
  logic signed [11:0] result;
  logic              alu_in_a_lsb;
  logic signed [11:0] alu_in_b;
  logic              alu_op;
  logic signed [11:0] alu_out;
`ifdef SEQ_CTRL_THRESH_EN
  logic signed [11:0] thresh_in;
  logic              act_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External serial ALU: add or subtract the single operand bit.
  assign alu_out = (alu_op == ALU_OP_SUB1) ? (alu_in_b - 12'(alu_in_a_lsb))
                                            : (alu_in_b + 12'(alu_in_a_lsb));

  alu_seq_ctrl #(.N_IN(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_vec        (a_vec),
    .w_vec        (w_vec),
    .bias_in      (bias_in),
`ifdef SEQ_CTRL_THRESH_EN
    .thresh_in    (thresh_in),
    .act_out      (act_out),
`endif
    .busy         (busy),
    .out_valid    (out_valid),
    .result       (result),
    .alu_in_a_lsb (alu_in_a_lsb),
    .alu_in_b     (alu_in_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pass; optional ignored start pulse in RUN cycle glitch_k (0 = none).
  task automatic run_pass(input string tag, input logic [N-1:0] a, input logic [N-1:0] w,
                          input logic [11:0] bias, input logic [11:0] exp_res,
                          input int glitch_k, input logic [11:0] thr, input logic exp_act);
    start   = 1'b1;
    a_vec   = a;
    w_vec   = w;
    bias_in = bias;
`ifdef SEQ_CTRL_THRESH_EN
    thresh_in = thr;
`endif
    tick();
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      check_eq($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
      check_eq($sformatf("%s vld c%0d", tag, k), {31'd0, out_valid}, 32'd0);
      check_eq($sformatf("%s lsb c%0d", tag, k), {31'd0, alu_in_a_lsb}, {31'd0, a[k-1]});
      check_eq($sformatf("%s op c%0d", tag, k), {31'd0, alu_op},
               {31'd0, (w[k-1] ? ALU_OP_ADD1 : ALU_OP_SUB1)});
      if (k == glitch_k) begin
        start   = 1'b1;
        a_vec   = '0;
        w_vec   = '0;
        bias_in = 12'sd100;
      end
      tick();
      start = 1'b0;
    end
    check_eq({tag, " done vld"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, " done busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, " result"}, {20'd0, result}, {20'd0, exp_res});
`ifdef SEQ_CTRL_THRESH_EN
    check_eq({tag, " act"}, {31'd0, act_out}, {31'd0, exp_act});
`endif
    tick();
    check_eq({tag, " post busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " post vld"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, " post op"}, {31'd0, alu_op}, {31'd0, ALU_OP_ADD1});
    check_eq({tag, " held result"}, {20'd0, result}, {20'd0, exp_res});
    if (glitch_k != 0) begin
      for (int j = 0; j < N + 2; j++) begin
        check_eq($sformatf("%s no 2nd vld %0d", tag, j), {31'd0, out_valid}, 32'd0);
        check_eq($sformatf("%s idle busy %0d", tag, j), {31'd0, busy}, 32'd0);
        tick();
      end
      check_eq({tag, " result kept"}, {20'd0, result}, {20'd0, exp_res});
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    a_vec   = 8'hFF;
    w_vec   = 8'hFF;
    bias_in = 12'sd7;
`ifdef SEQ_CTRL_THRESH_EN
    thresh_in = 12'sd0;
`endif
    tick();
    tick();
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst vld", {31'd0, out_valid}, 32'd0);
    check_eq("rst result", {20'd0, result}, 32'd0);
    check_eq("rst acc", {20'd0, alu_in_b}, 32'd0);
    check_eq("rst lsb", {31'd0, alu_in_a_lsb}, 32'd0);
    check_eq("rst op", {31'd0, alu_op}, {31'd0, ALU_OP_ADD1});
`ifdef SEQ_CTRL_THRESH_EN
    check_eq("rst act", {31'd0, act_out}, 32'd0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_eq("idle busy", {31'd0, busy}, 32'd0);

    run_pass("allplus",  8'hFF, 8'hFF, 12'd0,    12'd8,    0, 12'd8, 1'b1);
    run_pass("allminus", 8'hFF, 8'h00, 12'd0,    12'hFF8,  0, 12'd0, 1'b0);
    run_pass("cancel",   8'hAA, 8'hF0, 12'd5,    12'd5,    0, 12'd6, 1'b0);
    run_pass("glitch",   8'hFF, 8'hFF, 12'd0,    12'd8,    3, 12'd8, 1'b1);
    run_pass("edgepos",  8'h01, 8'h01, 12'h7FE,  12'h7FF,  0, 12'h7FF, 1'b1);
    run_pass("edgeneg",  8'h80, 8'h00, 12'h802,  12'h801,  0, 12'h801, 1'b1);

    // Reset in cycle t+4 of a pass.
    start   = 1'b1;
    a_vec   = 8'hFF;
    w_vec   = 8'hFF;
    bias_in = 12'sd20;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort busy", {31'd0, busy}, 32'd0);
    check_eq("abort result", {20'd0, result}, 32'd0);
    check_eq("abort vld", {31'd0, out_valid}, 32'd0);
    for (int j = 0; j < N + 2; j++) begin
      check_eq($sformatf("abort quiet vld %0d", j), {31'd0, out_valid}, 32'd0);
      tick();
    end
    run_pass("afterrst", 8'h0F, 8'h05, 12'hFFD, 12'hFFD, 0, 12'hFFE, 1'b0);

`ifdef SEQ_CTRL_THRESH_EN
    run_pass("thr8", 8'hFF, 8'hFF, 12'd0, 12'd8, 0, 12'd8, 1'b1);
    run_pass("thr9", 8'hFF, 8'hFF, 12'd0, 12'd8, 0, 12'd9, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer for the 12-bit serial add/subtract ALU in the neuron datapath. It takes a vector of input activation bits and a vector of weight bits, then steps the ALU once per bit. Each step adds or subtracts that activation bit to a running 12-bit signed accumulator, seeded with a bias. When the vector is finished it presents the neuron pre-activation with a one-cycle valid pulse. It sits between the layer-level control and the ALU and owns the accumulator register.

## Interface
- N_IN, default 64, is the number of activation/weight bit pairs per neuron, with 1 ≤ N_IN ≤ 1024.
- CNT_W, default $clog2(N_IN+1), is the width of the step counter.

Ports:
- clk, input, 1: clock. One clock domain.
- rst, input, 1: reset. Synchronous, active-high.
- start, input, 1: start request. Accepted only in IDLE.
- a_vec, input, N_IN: activation bits. Sampled on an accepted start.
- w_vec, input, N_IN: weight bits, where 1 means add and 0 means subtract. Sampled on an accepted start.
- bias_in, input, 12 (signed): initial accumulator value. Sampled on an accepted start.
- busy, output, 1: high while in RUN or DONE.
- out_valid, output, 1: one-cycle pulse while in DONE.
- result, output, 12 (signed): final accumulator value. Held until the next accepted start.
- alu_in_a_lsb, output, 1: ALU operand bit.
- alu_in_b, output, 12 (signed): ALU accumulator operand, driven from the accumulator register.
- alu_op, output, 1: ALU opcode, either ALU_OP_ADD1 or ALU_OP_SUB1.
- alu_out, input, 12 (signed): ALU result, combinational from the three ALU operand outputs.

## Operation
- There are three states: IDLE, RUN and DONE.
- In IDLE, start=1 loads the shift registers from a_vec and w_vec, loads acc from bias_in, sets cnt=0 and moves to RUN.
- In RUN, on each cycle:
  - alu_in_a_lsb is a_sh[0].
  - alu_op is ALU_OP_ADD1 when w_sh[0]=1, otherwise ALU_OP_SUB1.
  - acc ← alu_out, both shift registers shift right by one, and cnt increments.
- When cnt = N_IN-1, the update happens and the state moves to DONE.
- In DONE:
  - result ← acc and out_valid=1.
  - The state moves to IDLE on the next cycle.
- Bit 0 of each vector is consumed first.
- Outside RUN, alu_in_a_lsb=0 and alu_op=ALU_OP_ADD1, so alu_out equals acc.
- start is ignored while in RUN or DONE. There is no queueing and no error flag.
- start in the same cycle as rst is ignored, because reset wins.
- Arithmetic is 12-bit two's complement and wraps modulo 2^12 with no saturation. Callers keep |bias_in| + N_IN ≤ 2047.
- Reset values:
  - State is IDLE.
  - acc, result, cnt and both shift registers are 0.
  - busy=0 and out_valid=0.
  - alu_in_a_lsb=0 and alu_op=ALU_OP_ADD1.
- Reset in the middle of RUN or DONE aborts the pass with no out_valid, and result is zeroed.

## Timing
- If start is accepted at edge t, busy=1 from t+1.
- RUN occupies cycles t+1 through t+N_IN.
- DONE is at t+N_IN+1, and out_valid is high for that single cycle.
- busy falls at t+N_IN+2.
- The earliest next start is accepted at edge t+N_IN+2. Throughput is one neuron per N_IN+2 cycles.
- The ALU path is combinational within one cycle: register to ALU to acc register.

## Configuration
- SEQ_CTRL_THRESH_EN adds the input thresh_in [11:0] (signed), which is sampled on an accepted start.
- It also adds the output act_out (1 bit), which is registered in DONE as (acc ≥ thresh_in) and held like result. act_out resets to 0.
- Without the macro, neither port exists and the block behaves exactly as described above.

## Structure
- ALU_OP_ADD1, ALU_OP_SUB1 and the state encodings IDLE, RUN and DONE live in the shared control-signal header. That header is the same one the ALU uses.
- There is no sub-module. The ALU is instantiated alongside this block at the next level up, not inside it.

## Test plan
- N_IN=8, a=8'hFF, w=8'hFF, bias=0 → result=12'd8, with out_valid exactly at t+9 and busy high for cycles t+1 through t+9.
- N_IN=8, a=8'hFF, w=8'h00, bias=0 → result=12'hFF8 (-8).
- N_IN=8, a=8'hAA, w=8'hF0, bias=5 → result=5, because +2 and -2 cancel. Check alu_op per cycle follows the sequence SUB×4 then ADD×4.
- Pulse start at cycle t+3 of a pass → it is ignored, the first pass result is unchanged, and no second out_valid appears.
- Assert rst during RUN at cycle t+4 → the next cycle shows busy=0, result=0 and no out_valid. A following start then gives the correct result.
- With SEQ_CTRL_THRESH_EN, a=w=8'hFF and bias=0: thresh=8 → act_out=1, and thresh=9 → act_out=0.
